cp15_coprocessor: RTL and testbench
===================================

Name: cp15_coprocessor

Overview:
- System control coprocessor (CP15) for the LEG pipelined ARM core.
- Holds the ID, control, translation-table base, domain, fault-status, fault-address and FCSE PID registers.
- Decodes c7 cache and c8 TLB maintenance writes into one-cycle command strobes for the I$, D$ and MMU.
- Sits at the core's Memory stage, beside the caches and MMU; control bits 13/12/2 feed HighVec/I$-enable/D$-enable; tbase feeds the MMU.

Parameters:
- ID_CODE, 32'h41069260, value returned for c0 reads with opcode_2 = 0.
- CACHE_TYPE, 32'h0D152152, value returned for c0 reads with opcode_2 = 1.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous reset, active-high.
- CPUWriteEn  in  1  core MCR (write) request.
- CPUEn  in  1  core coprocessor access valid (MCR or MRC).
- MMUWriteEn  in  1  MMU write request (fault logging).
- MMUEn  in  1  MMU access valid.
- addr  in  4  CRn register number.
- CPUWriteData  in  32  core write data.
- MMUWriteData  in  32  MMU write data.
- opcode_2  in  3  ARM opcode_2 field.
- CRm  in  4  ARM CRm field.
- StallCP  out  1  core must hold its CP15 access this cycle.
- INVI  out  1  invalidate I$.
- INVD  out  1  invalidate D$.
- InvAll  out  1  invalidate is whole-cache (else by address).
- CleanI  out  1  clean I$ (always 0; no dirty lines).
- CleanD  out  1  clean D$.
- TLBFlushD  out  1  flush D-TLB.
- TLBFlushI  out  1  flush I-TLB.
- rd  out  32  read data for addr.
- control  out  32  live c1 control register.
- AddrOp  out  1  maintenance op uses address in CPUWriteData.
- tbase  out  32  c2 value, bits 13:0 forced 0.

Behaviour:
- Registers and reset values (async reset):
  - c1 = 32'h00000078; bits 6:3 always read 1 (write-ignored).
  - c2 = 0, c3 = 0, c5 = 0, c6 = 0, c13 = 0.
  - Outputs are combinational from state/inputs; all strobes are 0 while reset is high.
- cpuwr = CPUEn & CPUWriteEn; mmuwr = MMUEn & MMUWriteEn.
- Priority: MMU over CPU.
  - StallCP = CPUEn & MMUEn, combinational.
  - A stalled CPU write neither updates state nor fires strobes that cycle.
- Writes (on clk rising edge):
  - CPU write, not stalled: addr 1/2/3/5/6/13 update the named register; c2 stores bits 31:14 only.
  - MMU write: addr 5 or 6 only; other addr values are ignored.
  - Writes to c0, c4, c7–c12, c14, c15 update no register.
- Reads (rd, combinational, same cycle):
  - c0: ID_CODE when opcode_2 = 0, CACHE_TYPE when opcode_2 = 1, else ID_CODE.
  - c1/2/3/5/6/13: current register value.
  - All other CRn: 0.
  - A write and a read of the same register in one cycle returns the old value.
- c7 strobes: high only in the cycle of an unstalled cpuwr with addr = 7, decoded on (CRm, opcode_2):
  - (7,0): INVI = INVD = InvAll = 1.
  - (5,0): INVI, InvAll.
  - (5,1): INVI, AddrOp.
  - (6,0): INVD, InvAll.
  - (6,1): INVD, AddrOp.
  - (10,1): CleanD, AddrOp.
  - (14,1): CleanD, INVD, AddrOp.
  - Other (CRm, opcode_2) combinations: no strobes.
- c8 strobes (addr = 8), ignoring opcode_2:
  - CRm 7: TLBFlushI and TLBFlushD.
  - CRm 5: TLBFlushI.
  - CRm 6: TLBFlushD.
- All strobes are single-cycle level outputs and return to 0 the next cycle unless the write repeats.
- Reset asserted mid-operation forces all registers to reset values immediately; no pending state exists.

Test Plan:
- Reset → control = 32'h00000078, tbase = 0, rd(addr 0, opcode_2 = 0) = 32'h41069260, all strobes 0.
- CPU write c1 = 32'h00003005 → next cycle control = 32'h0000307D; control[13], [12] and [2] all 1.
- CPU write c2 = 32'hABCD_FFFF → tbase = 32'hABCD_C000; rd(addr 2) returns the same.
- CPU write addr 7, CRm 7, opcode_2 0 → INVI = INVD = InvAll = 1 for exactly one cycle; CRm 10 / opcode_2 1 → CleanD = AddrOp = 1, INVD = 0.
- CPU write addr 8, CRm 6 → TLBFlushD = 1, TLBFlushI = 0.
- CPUEn and MMUEn both high, MMU writes c6 = 32'h1234 while CPU writes c6 = 32'h5678 → StallCP = 1, c6 = 32'h1234; CPU write repeated next cycle → c6 = 32'h5678.

Source files
------------

// File: rtl/cp15_coprocessor_if.sv
// cp15_coprocessor_if: core/MMU access bus and command/status outputs of the CP15 coprocessor
interface cp15_coprocessor_if;
  logic        CPUWriteEn;
  logic        CPUEn;
  logic        MMUWriteEn;
  logic        MMUEn;
  logic [3:0]  addr;
  logic [31:0] CPUWriteData;
  logic [31:0] MMUWriteData;
  logic [2:0]  opcode_2;
  logic [3:0]  CRm;
  logic        StallCP;
  logic        INVI;
  logic        INVD;
  logic        InvAll;
  logic        CleanI;
  logic        CleanD;
  logic        TLBFlushD;
  logic        TLBFlushI;
  logic [31:0] rd;
  logic [31:0] control;
  logic        AddrOp;
  logic [31:0] tbase;
  modport master (
    output CPUWriteEn, CPUEn, MMUWriteEn, MMUEn, addr, CPUWriteData, MMUWriteData, opcode_2, CRm,
    input  StallCP, INVI, INVD, InvAll, CleanI, CleanD, TLBFlushD, TLBFlushI, rd, control, AddrOp, tbase
  );
  modport slave (
    input  CPUWriteEn, CPUEn, MMUWriteEn, MMUEn, addr, CPUWriteData, MMUWriteData, opcode_2, CRm,
    output StallCP, INVI, INVD, InvAll, CleanI, CleanD, TLBFlushD, TLBFlushI, rd, control, AddrOp, tbase
  );
endinterface

// File: rtl/cp15_coprocessor.sv
// cp15_coprocessor: CP15 system control registers plus c7/c8 cache and TLB maintenance strobes
module cp15_coprocessor #(
  parameter logic [31:0] ID_CODE    = 32'h41069260,
  parameter logic [31:0] CACHE_TYPE = 32'h0D152152
) (
  input logic clk,
  input logic reset,
  cp15_coprocessor_if.slave bus
);
  logic [31:0] c1_q, c1_d, c2_q, c2_d, c3_q, c3_d, c5_q, c5_d, c6_q, c6_d, c13_q, c13_d;
  logic        cpu_ok, mmu_wr, c7, c8;
  logic [6:0]  op;
  // The MMU owns the bus when both request, so a CPU write only lands when MMUEn is low.
  always_comb begin
    cpu_ok = bus.CPUEn & bus.CPUWriteEn & ~bus.MMUEn & ~reset;
    mmu_wr = bus.MMUEn & bus.MMUWriteEn;
    c1_d   = cpu_ok && bus.addr == 4'd1  ? bus.CPUWriteData | 32'h78 : c1_q;
    c2_d   = cpu_ok && bus.addr == 4'd2  ? {bus.CPUWriteData[31:14], 14'b0} : c2_q;
    c3_d   = cpu_ok && bus.addr == 4'd3  ? bus.CPUWriteData : c3_q;
    c5_d   = mmu_wr && bus.addr == 4'd5  ? bus.MMUWriteData :
             cpu_ok && bus.addr == 4'd5  ? bus.CPUWriteData : c5_q;
    c6_d   = mmu_wr && bus.addr == 4'd6  ? bus.MMUWriteData :
             cpu_ok && bus.addr == 4'd6  ? bus.CPUWriteData : c6_q;
    c13_d  = cpu_ok && bus.addr == 4'd13 ? bus.CPUWriteData : c13_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      c1_q  <= 32'h00000078;
      c2_q  <= '0;
      c3_q  <= '0;
      c5_q  <= '0;
      c6_q  <= '0;
      c13_q <= '0;
    end else begin
      c1_q  <= c1_d;
      c2_q  <= c2_d;
      c3_q  <= c3_d;
      c5_q  <= c5_d;
      c6_q  <= c6_d;
      c13_q <= c13_d;
    end
  always_comb begin
    case (bus.addr)
      4'd0:    bus.rd = bus.opcode_2 == 3'd1 ? CACHE_TYPE : ID_CODE;
      4'd1:    bus.rd = c1_q;
      4'd2:    bus.rd = c2_q;
      4'd3:    bus.rd = c3_q;
      4'd5:    bus.rd = c5_q;
      4'd6:    bus.rd = c6_q;
      4'd13:   bus.rd = c13_q;
      default: bus.rd = '0;
    endcase
  end
  assign c7  = cpu_ok && bus.addr == 4'd7;
  assign c8  = cpu_ok && bus.addr == 4'd8;
  assign op  = {bus.CRm, bus.opcode_2};
  assign bus.StallCP   = bus.CPUEn & bus.MMUEn;
  assign bus.INVI      = c7 && (op == {4'd7, 3'd0} || op == {4'd5, 3'd0} || op == {4'd5, 3'd1});
  assign bus.INVD      = c7 && (op == {4'd7, 3'd0} || op == {4'd6, 3'd0} || op == {4'd6, 3'd1} || op == {4'd14, 3'd1});
  assign bus.InvAll    = c7 && (op == {4'd7, 3'd0} || op == {4'd5, 3'd0} || op == {4'd6, 3'd0});
  assign bus.CleanI    = 1'b0;
  assign bus.CleanD    = c7 && (op == {4'd10, 3'd1} || op == {4'd14, 3'd1});
  assign bus.AddrOp    = c7 && (op == {4'd5, 3'd1} || op == {4'd6, 3'd1} || op == {4'd10, 3'd1} || op == {4'd14, 3'd1});
  assign bus.TLBFlushI = c8 && (bus.CRm == 4'd7 || bus.CRm == 4'd5);
  assign bus.TLBFlushD = c8 && (bus.CRm == 4'd7 || bus.CRm == 4'd6);
  assign bus.control   = c1_q;
  assign bus.tbase     = c2_q;
endmodule

// File: tb/tb_cp15_coprocessor.sv
// tb_cp15_coprocessor: directed and random checks of cp15_coprocessor against a register-array model
module tb_cp15_coprocessor;
  localparam logic [31:0] ID = 32'h41069260, CT = 32'h0D152152;
  logic clk = 0, reset = 1;
  int checks = 0, errs = 0;
  logic [31:0] m [16];
  logic [7:0] stb;
  cp15_coprocessor_if bus();
  cp15_coprocessor dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  assign stb = {bus.INVI, bus.INVD, bus.InvAll, bus.CleanI, bus.CleanD, bus.TLBFlushD, bus.TLBFlushI, bus.AddrOp};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit held(input logic [3:0] a);
    return a inside {4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd13};
  endfunction

  function automatic logic [31:0] exp_rd(input logic [3:0] a, input logic [2:0] o2);
    if (a == 4'd0) return o2 == 3'd1 ? CT : ID;
    return held(a) ? m[a] : 32'h0;
  endfunction

  // bit order: INVI INVD InvAll CleanI CleanD TLBFlushD TLBFlushI AddrOp
  function automatic logic [7:0] exp_stb(input bit go, input logic [3:0] a, input logic [3:0] cr, input logic [2:0] o2);
    if (!go) return 8'h00;
    if (a == 4'd7)
      case ({cr, o2})
        {4'd7, 3'd0}:  return 8'hE0;
        {4'd5, 3'd0}:  return 8'hA0;
        {4'd5, 3'd1}:  return 8'h81;
        {4'd6, 3'd0}:  return 8'h60;
        {4'd6, 3'd1}:  return 8'h41;
        {4'd10, 3'd1}: return 8'h09;
        {4'd14, 3'd1}: return 8'h49;
        default:       return 8'h00;
      endcase
    if (a == 4'd8) return cr == 4'd7 ? 8'h06 : cr == 4'd5 ? 8'h02 : cr == 4'd6 ? 8'h04 : 8'h00;
    return 8'h00;
  endfunction

  task automatic model_reset();
    foreach (m[i]) m[i] = 32'h0;
    m[1] = 32'h78;
  endtask

  task automatic drive(input bit ce, cw, me, mw, input logic [3:0] a, input logic [31:0] cd, md,
                       input logic [2:0] o2, input logic [3:0] cr);
    bus.CPUEn = ce; bus.CPUWriteEn = cw; bus.MMUEn = me; bus.MMUWriteEn = mw;
    bus.addr = a; bus.CPUWriteData = cd; bus.MMUWriteData = md; bus.opcode_2 = o2; bus.CRm = cr;
  endtask

  // Called right after a rising edge; checks this cycle's combinational view, then commits at the next edge.
  task automatic step(input string tag, input bit ce, cw, me, mw, input logic [3:0] a, input logic [31:0] cd, md,
                      input logic [2:0] o2, input logic [3:0] cr);
    bit go;
    #1 drive(ce, cw, me, mw, a, cd, md, o2, cr);
    #2;
    go = ce && cw && !me;
    chk({tag, ".rd"}, bus.rd, exp_rd(a, o2));
    chk({tag, ".stall"}, {31'b0, bus.StallCP}, {31'b0, ce && me});
    chk({tag, ".stb"}, {24'b0, stb}, {24'b0, exp_stb(go, a, cr, o2)});
    chk({tag, ".control"}, bus.control, m[1]);
    chk({tag, ".tbase"}, bus.tbase, m[2]);
    if (me && mw && (a == 4'd5 || a == 4'd6)) m[a] = md;
    else if (go && held(a)) m[a] = a == 4'd1 ? cd | 32'h78 : a == 4'd2 ? cd & 32'hFFFF_C000 : cd;
    @(posedge clk);
  endtask

  initial begin
    logic [3:0] cr_pool [6];
    cr_pool = '{4'd5, 4'd6, 4'd7, 4'd10, 4'd14, 4'd0};
    model_reset();
    drive(0, 0, 0, 0, 4'd0, 0, 0, 3'd0, 4'd0);
    repeat (2) @(posedge clk);
    #1 chk("rst.rd_id", bus.rd, ID);
    chk("rst.control", bus.control, 32'h78);
    chk("rst.tbase", bus.tbase, 32'h0);
    drive(1, 1, 0, 0, 4'd7, 0, 0, 3'd0, 4'd7);
    #1 chk("rst.stb", {24'b0, stb}, 32'h0);
    drive(0, 0, 0, 0, 4'd0, 0, 0, 3'd0, 4'd0);
    reset = 0;
    @(posedge clk);
    step("c1wr",   1, 1, 0, 0, 4'd1, 32'h3005, 0, 3'd0, 4'd0);
    step("c1rd",   1, 0, 0, 0, 4'd1, 0, 0, 3'd0, 4'd0);
    chk("c1.bits", {29'b0, bus.control[13], bus.control[12], bus.control[2]}, 32'h7);
    chk("c1.val", bus.control, 32'h307D);
    step("c2wr",   1, 1, 0, 0, 4'd2, 32'hABCD_FFFF, 0, 3'd0, 4'd0);
    step("c2rd",   1, 0, 0, 0, 4'd2, 0, 0, 3'd0, 4'd0);
    chk("c2.tbase", bus.tbase, 32'hABCD_C000);
    step("inv_all", 1, 1, 0, 0, 4'd7, 0, 0, 3'd0, 4'd7);
    step("inv_off", 0, 0, 0, 0, 4'd7, 0, 0, 3'd0, 4'd7);
    step("clean_d", 1, 1, 0, 0, 4'd7, 32'h1000, 0, 3'd1, 4'd10);
    step("tlb_d",  1, 1, 0, 0, 4'd8, 0, 0, 3'd3, 4'd6);
    step("c0_ct",  1, 0, 0, 0, 4'd0, 0, 0, 3'd1, 4'd0);
    step("c0_oth", 1, 0, 0, 0, 4'd0, 0, 0, 3'd5, 4'd0);
    step("stall",  1, 1, 1, 1, 4'd6, 32'h5678, 32'h1234, 3'd0, 4'd0);
    step("retry",  1, 1, 0, 0, 4'd6, 32'h5678, 0, 3'd0, 4'd0);
    step("c6rd",   1, 0, 0, 0, 4'd6, 0, 0, 3'd0, 4'd0);
    chk("c6.val", bus.rd, 32'h5678);
    step("stall_c7", 1, 1, 1, 0, 4'd7, 0, 0, 3'd0, 4'd7);
    step("mmu_c3", 0, 0, 1, 1, 4'd3, 0, 32'hDEAD, 3'd0, 4'd0);
    step("c3rd",   1, 0, 0, 0, 4'd3, 0, 0, 3'd0, 4'd0);
    for (int i = 0; i < 400; i++) begin
      logic [3:0] a;
      a = $urandom_range(0, 3) == 0 ? 4'($urandom) : ($urandom_range(0, 1) ? 4'd7 : 4'($urandom_range(0, 8)));
      step("rnd", 1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom),
           a, $urandom, $urandom, 3'($urandom_range(0, 2)), cr_pool[$urandom_range(0, 5)]);
    end
    step("pre_c3",  1, 1, 0, 0, 4'd3, 32'h55AA, 0, 3'd0, 4'd0);
    #1 reset = 1;
    drive(1, 1, 0, 0, 4'd3, 32'h1, 0, 3'd0, 4'd0);
    #1 chk("mid.control", bus.control, 32'h78);
    chk("mid.tbase", bus.tbase, 32'h0);
    chk("mid.c3", bus.rd, 32'h0);
    drive(1, 1, 0, 0, 4'd7, 0, 0, 3'd0, 4'd7);
    #1 chk("mid.stb", {24'b0, stb}, 32'h0);
    model_reset();
    drive(0, 0, 0, 0, 4'd0, 0, 0, 3'd0, 4'd0);
    reset = 0;
    @(posedge clk);
    step("post_c1", 1, 0, 0, 0, 4'd1, 0, 0, 3'd0, 4'd0);
    step("post_c7", 1, 1, 0, 0, 4'd7, 0, 0, 3'd1, 4'd14);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
